// File: rtl/sobel_edge_pipe_pkg.sv
// Shared types and constants for the Sobel edge pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int GRAD_W  = 11;
  localparam int MAG_MAX = 255;

  typedef logic [7:0]               pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        gsum_t;

  // Magnitude of a gradient; -1020..1020 always fits the unsigned result.
  function automatic gsum_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? gsum_t'(-g) : gsum_t'(g);
  endfunction

endpackage

// File: rtl/sobel_edge_pipe_if.sv
// Pixel-in / result-out bundle of the Sobel edge pipeline.
// Latency: n/a (wires only).
// Backpressure: none; the source streams with in_valid, the sink must accept.
interface sobel_edge_pipe_if #(
  parameter int COORD_W = 11,
  parameter int CNT_W   = 20
);
  import sobel_pkg::*;

  logic               in_valid;
  pixel_t             ul, uc, ur;
  pixel_t             ml, mc, mr;
  pixel_t             dl, dc, dr;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  pixel_t             thresh;

  logic               out_valid;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  pixel_t             mag;
  logic               is_edge;
  logic               frame_done;
  logic [CNT_W-1:0]   edge_count;
  logic               coord_err;

  modport master (
    output in_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr, in_x, in_y, thresh,
    input  out_valid, out_x, out_y, mag, is_edge, frame_done, edge_count, coord_err
  );

  modport slave (
    input  in_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr, in_x, in_y, thresh,
    output out_valid, out_x, out_y, mag, is_edge, frame_done, edge_count, coord_err
  );

endinterface

// File: rtl/sobel_edge_pipe_grad_core.sv
// Combinational Sobel kernels: Gx/Gy from a window, and |Gx|+|Gy| from registered gradients.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module sobel_grad_core
  import sobel_pkg::*;
(
  input  pixel_t ul,
  input  pixel_t uc,
  input  pixel_t ur,
  input  pixel_t ml,
  input  pixel_t mr,
  input  pixel_t dl,
  input  pixel_t dc,
  input  pixel_t dr,
  output grad_t  gx,
  output grad_t  gy,
  input  grad_t  gx_in,
  input  grad_t  gy_in,
  output gsum_t  abs_sum
);

  // All arithmetic is carried at GRAD_W bits so +/-1020 never overflows.
  grad_t left_sum, right_sum, up_sum, down_sum;

  assign left_sum  = grad_t'(ul) + (grad_t'(ml) << 1) + grad_t'(dl);
  assign right_sum = grad_t'(ur) + (grad_t'(mr) << 1) + grad_t'(dr);
  assign up_sum    = grad_t'(ul) + (grad_t'(uc) << 1) + grad_t'(ur);
  assign down_sum  = grad_t'(dl) + (grad_t'(dc) << 1) + grad_t'(dr);

  assign gx = right_sum - left_sum;
  assign gy = down_sum - up_sum;

  // Worst case 1020+1020=2040 still fits GRAD_W unsigned bits.
  assign abs_sum = abs_grad(gx_in) + abs_grad(gy_in);

endmodule

// File: rtl/sobel_edge_pipe.sv
// Three-stage Sobel edge detector: S1 gradients, S2 |Gx|+|Gy|, S3 saturate/threshold/border.
// Latency: 3 cycles in_valid -> out_valid, one pixel per cycle; no backpressure.
// Optional SOBEL_EDGE_COUNT_EN adds a per-frame edge counter on edge_count (tied to 0 otherwise).
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int COORD_W = 11,
  parameter int CNT_W   = 20
) (
  input logic             CAMERA_CLK,
  input logic             rst,
  sobel_edge_pipe_if.slave bus
);

  localparam logic [COORD_W:0]   X_LIM  = (COORD_W+1)'(HEIGHT);
  localparam logic [COORD_W:0]   Y_LIM  = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(WIDTH - 1);

  // Input qualification
  logic in_ok, in_border;
  assign in_ok     = ({1'b0, bus.in_x} < X_LIM) && ({1'b0, bus.in_y} < Y_LIM);
  assign in_border = (bus.in_x == '0) || (bus.in_x == X_LAST) ||
                     (bus.in_y == '0) || (bus.in_y == Y_LAST);

  // The centre tap has a zero weight in both kernels.
  logic unused_mc;
  assign unused_mc = ^bus.mc;

  // Stage registers
  logic               s1_valid, s1_border;
  logic [COORD_W-1:0] s1_x, s1_y;
  pixel_t             s1_thresh;
  grad_t              s1_gx, s1_gy;
  grad_t              gx_n, gy_n;

  logic               s2_valid, s2_border;
  logic [COORD_W-1:0] s2_x, s2_y;
  pixel_t             s2_thresh;
  gsum_t              s2_sum;
  gsum_t              sum_n;

  logic               out_valid, frame_done, coord_err, is_edge;
  logic [COORD_W-1:0] out_x, out_y;
  pixel_t             mag;
  logic [CNT_W-1:0]   edge_cnt;

  sobel_grad_core u_core (
    .ul      (bus.ul),
    .uc      (bus.uc),
    .ur      (bus.ur),
    .ml      (bus.ml),
    .mr      (bus.mr),
    .dl      (bus.dl),
    .dc      (bus.dc),
    .dr      (bus.dr),
    .gx      (gx_n),
    .gy      (gy_n),
    .gx_in   (s1_gx),
    .gy_in   (s1_gy),
    .abs_sum (sum_n)
  );

  // Stage valids; out-of-range pixels never enter the pipe and reset flushes it.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid && in_ok;
      s2_valid <= s1_valid;
    end
  end

  // S1 payload: gradients, coordinates, threshold and border flag for the accepted pixel.
  always_ff @(posedge CAMERA_CLK) begin
    if (bus.in_valid) begin
      s1_gx     <= gx_n;
      s1_gy     <= gy_n;
      s1_x      <= bus.in_x;
      s1_y      <= bus.in_y;
      s1_thresh <= bus.thresh;
      s1_border <= in_border;
    end
  end

  // S2 payload: absolute gradient sum travels with its pixel's side data.
  always_ff @(posedge CAMERA_CLK) begin
    if (s1_valid) begin
      s2_sum    <= sum_n;
      s2_x      <= s1_x;
      s2_y      <= s1_y;
      s2_thresh <= s1_thresh;
      s2_border <= s1_border;
    end
  end

  // S3 decision: saturate to 8 bits, force border pixels to zero, compare with threshold.
  pixel_t sat_mag, res_mag;
  logic   res_edge;
  always_comb begin
    sat_mag  = (|s2_sum[GRAD_W-1:8]) ? pixel_t'(MAG_MAX) : s2_sum[7:0];
    res_mag  = s2_border ? '0 : sat_mag;
    res_edge = !s2_border && (sat_mag >= s2_thresh);
  end

  // Output registers; payload holds its last value across bubbles.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      mag        <= '0;
      is_edge    <= 1'b0;
    end else begin
      out_valid  <= s2_valid;
      frame_done <= s2_valid && (s2_x == X_LAST) && (s2_y == Y_LAST);
      if (s2_valid) begin
        out_x   <= s2_x;
        out_y   <= s2_y;
        mag     <= res_mag;
        is_edge <= res_edge;
      end
    end
  end

  // Sticky flag for any valid pixel whose coordinates fall outside the frame.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst)
      coord_err <= 1'b0;
    else if (bus.in_valid && !in_ok)
      coord_err <= 1'b1;
  end

`ifdef SOBEL_EDGE_COUNT_EN
  logic [CNT_W-1:0] acc, acc_next;

  // Running edge total for the current frame, saturating at all-ones.
  always_comb begin
    acc_next = acc;
    if (out_valid && is_edge && (acc != '1))
      acc_next = acc + 1'b1;
  end

  // Publish the frame total on the last pixel (including its own edge) and restart.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      acc      <= '0;
      edge_cnt <= '0;
    end else if (frame_done) begin
      acc      <= '0;
      edge_cnt <= acc_next;
    end else begin
      acc      <= acc_next;
    end
  end
`else
  assign edge_cnt = '0;
`endif

  assign bus.out_valid  = out_valid;
  assign bus.out_x      = out_x;
  assign bus.out_y      = out_y;
  assign bus.mag        = mag;
  assign bus.is_edge    = is_edge;
  assign bus.frame_done = frame_done;
  assign bus.edge_count = edge_cnt;
  assign bus.coord_err  = coord_err;

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed bench for sobel_edge_pipe on a small 12x16 frame.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Edge-count expectations follow whether SOBEL_EDGE_COUNT_EN is defined.
module tb_sobel_edge_pipe;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int CW = 11;
  localparam int NW = 20;

  // Windows packed as {ul,uc,ur,ml,mc,mr,dl,dc,dr}
  localparam logic [71:0] UNI   = {9{8'd100}};
  localparam logic [71:0] STEP  = {8'd0, 8'd77, 8'd255, 8'd0, 8'd77, 8'd255, 8'd0, 8'd77, 8'd255};
  localparam logic [71:0] SMALL = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

`ifdef SOBEL_EDGE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_edge_pipe_if #(.COORD_W(CW), .CNT_W(NW)) bus ();

  sobel_edge_pipe #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CNT_W(NW)) dut (
    .CAMERA_CLK (clk),
    .rst        (rst),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y, input logic [71:0] w,
                       input logic [7:0] th);
    bus.in_valid = v;
    bus.in_x     = CW'(x);
    bus.in_y     = CW'(y);
    {bus.ul, bus.uc, bus.ur, bus.ml, bus.mc, bus.mr, bus.dl, bus.dc, bus.dr} = w;
    bus.thresh   = th;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, UNI, 8'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Sends one pixel, waits three edges and returns what the output stage shows.
  task automatic run_pixel(input int x, input int y, input logic [71:0] w, input logic [7:0] th,
                           output logic early, output logic ov, output logic [CW-1:0] ox,
                           output logic [CW-1:0] oy, output logic [7:0] m, output logic e);
    drive(1'b1, x, y, w, th);
    step();
    early = bus.out_valid;
    bus.in_valid = 1'b0;
    step();
    early = early | bus.out_valid;
    step();
    ov = bus.out_valid;
    ox = bus.out_x;
    oy = bus.out_y;
    m  = bus.mag;
    e  = bus.is_edge;
  endtask

  function automatic bit px_step(input int r, input int c, input int sel);
    if (sel == 0)
      return (r == 1 && c == 1) || (r == 2 && c == 5) || (r == 3 && c == 7) ||
             (r == 4 && c == 14) || (r == 7 && c == 2) || (r == 9 && c == 9) ||
             (r == 10 && c == 14) ||
             (r == 0 && c == 3) || (r == 11 && c == 8) || (r == 5 && c == 0);
    return (r == 2 && c == 2) || (r == 8 && c == 13) || (r == 11 && c == 15);
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_x !== '0) begin bad++; $display("FAIL rst_out_x got=%0d want=0", bus.out_x); end
    total++; if (bus.out_y !== '0) begin bad++; $display("FAIL rst_out_y got=%0d want=0", bus.out_y); end
    total++; if (bus.mag !== 8'd0) begin bad++; $display("FAIL rst_mag got=%0d want=0", bus.mag); end
    total++; if (bus.is_edge !== 1'b0) begin bad++; $display("FAIL rst_edge got=%b want=0", bus.is_edge); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.edge_count !== '0) begin bad++; $display("FAIL rst_edge_count got=%0d want=0", bus.edge_count); end
    total++; if (bus.coord_err !== 1'b0) begin bad++; $display("FAIL rst_coord_err got=%b want=0", bus.coord_err); end
  endtask

  task automatic test_uniform();
    logic early, ov, e;
    logic [CW-1:0] ox, oy;
    logic [7:0] m;
    run_pixel(10, 10, UNI, 8'd50, early, ov, ox, oy, m, e);
    total++; if (early !== 1'b0) begin bad++; $display("FAIL uni_early got=%b want=0", early); end
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL uni_valid got=%b want=1", ov); end
    total++; if (m !== 8'd0 || e !== 1'b0) begin bad++; $display("FAIL uni_mag_edge got=%0d/%b want=0/0", m, e); end
    total++; if (ox !== CW'(10) || oy !== CW'(10)) begin bad++; $display("FAIL uni_coord got=%0d,%0d want=10,10", ox, oy); end
  endtask

  task automatic test_step();
    logic early, ov, e;
    logic [CW-1:0] ox, oy;
    logic [7:0] m;
    run_pixel(5, 5, STEP, 8'd100, early, ov, ox, oy, m, e);
    total++; if (ov !== 1'b1 || m !== 8'd255 || e !== 1'b1) begin bad++; $display("FAIL step_sat got v=%b mag=%0d edge=%b want 1/255/1", ov, m, e); end
  endtask

  task automatic test_border();
    int bx[4] = '{0, 5, H-1, 5};
    int by[4] = '{5, W-1, 5, 0};
    logic early, ov, e;
    logic [CW-1:0] ox, oy;
    logic [7:0] m;
    for (int i = 0; i < 4; i++) begin
      run_pixel(bx[i], by[i], STEP, 8'd0, early, ov, ox, oy, m, e);
      total++;
      if (ov !== 1'b1 || m !== 8'd0 || e !== 1'b0 || ox !== CW'(bx[i]) || oy !== CW'(by[i])) begin
        bad++;
        $display("FAIL border_%0d got v=%b mag=%0d edge=%b at %0d,%0d want 1/0/0 at %0d,%0d",
                 i, ov, m, e, ox, oy, bx[i], by[i]);
      end
    end
  endtask

  task automatic test_threshold();
    logic early, ov, e;
    logic [CW-1:0] ox, oy;
    logic [7:0] m;
    run_pixel(3, 3, SMALL, 8'd20, early, ov, ox, oy, m, e);
    total++; if (m !== 8'd20 || e !== 1'b1) begin bad++; $display("FAIL thr_equal got mag=%0d edge=%b want 20/1", m, e); end
    run_pixel(3, 4, SMALL, 8'd21, early, ov, ox, oy, m, e);
    total++; if (m !== 8'd20 || e !== 1'b0) begin bad++; $display("FAIL thr_above got mag=%0d edge=%b want 20/0", m, e); end
    run_pixel(4, 4, UNI, 8'd0, early, ov, ox, oy, m, e);
    total++; if (m !== 8'd0 || e !== 1'b1) begin bad++; $display("FAIL thr_zero got mag=%0d edge=%b want 0/1", m, e); end
  endtask

  task automatic test_back_to_back();
    logic        vin[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [71:0] win[4]  = '{SMALL, STEP, STEP, UNI};
    logic [7:0]  mags[4] = '{8'd20, 8'd0, 8'd255, 8'd0};
    int          xs[4]   = '{2, 7, 3, 4};
    logic [7:0]  last_mag = 8'd0;
    int          last_x = 0;
    logic        exp_v;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(vin[i], xs[i], xs[i], win[i], 8'd100);
      else       bus.in_valid = 1'b0;
      step();
      if (i >= 2) begin
        exp_v = (i - 2 < 4) ? vin[i-2] : 1'b0;
        if (exp_v) begin
          last_mag = mags[i-2];
          last_x   = xs[i-2];
        end
        total++;
        if (bus.out_valid !== exp_v || bus.mag !== last_mag || bus.out_x !== CW'(last_x)) begin
          bad++;
          $display("FAIL b2b_cycle%0d got v=%b mag=%0d x=%0d want v=%b mag=%0d x=%0d",
                   i, bus.out_valid, bus.mag, bus.out_x, exp_v, last_mag, last_x);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 5, 5, STEP, 8'd0);
    step();
    drive(1'b1, 6, 6, STEP, 8'd0);
    step();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_cycle%0d got v=%b want 0", i, bus.out_valid); end
    end
    rst = 1'b1;
    drive(1'b1, 5, 5, STEP, 8'd0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_same_cycle%0d got v=%b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_coord_err();
    logic seen = 1'b0;
    total++; if (bus.coord_err !== 1'b0) begin bad++; $display("FAIL cerr_before got=%b want=0", bus.coord_err); end
    drive(1'b1, H, 3, STEP, 8'd0);
    step();
    drive(1'b1, 3, W, STEP, 8'd0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | bus.out_valid;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL cerr_dropped got out_valid=%b want 0", seen); end
    total++; if (bus.coord_err !== 1'b1) begin bad++; $display("FAIL cerr_sticky got=%b want=1", bus.coord_err); end
    do_reset();
    total++; if (bus.coord_err !== 1'b0) begin bad++; $display("FAIL cerr_reset got=%b want=0", bus.coord_err); end
  endtask

  task automatic run_frame(input int sel, input int exp_edges);
    int fd_cnt = 0;
    int edges = 0;
    int fx = -1;
    int fy = -1;
    int want_cnt;
    for (int n = 0; n < H * W + 4; n++) begin
      if (n < H * W)
        drive(1'b1, n / W, n % W, px_step(n / W, n % W, sel) ? STEP : UNI, 8'd100);
      else
        bus.in_valid = 1'b0;
      step();
      if (bus.out_valid && bus.is_edge) edges++;
      if (bus.frame_done) begin
        fd_cnt++;
        fx = bus.out_valid ? int'(bus.out_x) : -2;
        fy = int'(bus.out_y);
      end
    end
    want_cnt = CNT_ON ? exp_edges : 0;
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL frame%0d_done_pulses got=%0d want=1", sel, fd_cnt); end
    total++; if (fx != H-1 || fy != W-1) begin bad++; $display("FAIL frame%0d_done_pos got=%0d,%0d want=%0d,%0d", sel, fx, fy, H-1, W-1); end
    total++; if (edges != exp_edges) begin bad++; $display("FAIL frame%0d_edges_seen got=%0d want=%0d", sel, edges, exp_edges); end
    total++; if (bus.edge_count !== NW'(want_cnt)) begin bad++; $display("FAIL frame%0d_edge_count got=%0d want=%0d", sel, bus.edge_count, want_cnt); end
  endtask

  task automatic test_frames();
    do_reset();
    run_frame(0, 7);
    run_frame(1, 2);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_step();
    test_border();
    test_threshold();
    test_back_to_back();
    test_reset_inflight();
    test_coord_err();
    test_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_edge_pipe.md
SOBEL_EDGE_PIPE -- requirements
Module: sobel_edge_pipe

Interface
REQ-001 Parameter WIDTH, default 768, sets the image width in pixels (columns).
REQ-002 Parameter HEIGHT, default 512, sets the image height in pixels (rows).
REQ-003 Parameter COORD_W, default 11, sets the coordinate bit width.
REQ-004 Parameter CNT_W, default 20, sets the edge-counter width.
REQ-005 Port CAMERA_CLK, input, 1 bit: clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port in_valid, input, 1 bit: window and coordinates are valid this cycle.
REQ-008 Ports ul, uc, ur, ml, mc, mr, dl, dc, dr, input, 8 bits each: 3x3 grey window (u/m/d = row above/centre/below; l/c/r = column left/centre/right).
REQ-009 Port in_x, input, COORD_W bits: centre row index, 0..HEIGHT-1.
REQ-010 Port in_y, input, COORD_W bits: centre column index, 0..WIDTH-1.
REQ-011 Port thresh, input, 8 bits: edge threshold, sampled together with the pixel.
REQ-012 Port out_valid, output, 1 bit: output pixel is valid.
REQ-013 Ports out_x, out_y, output, COORD_W bits: coordinates of the output pixel.
REQ-014 Port mag, output, 8 bits: saturated gradient magnitude.
REQ-015 Port edge, output, 1 bit: edge decision.
REQ-016 Port frame_done, output, 1 bit: pulse on the last pixel of a frame.
REQ-017 Port edge_count, output, CNT_W bits: edge total of the last completed frame.
REQ-018 Port coord_err, output, 1 bit: sticky out-of-range coordinate flag.

Function
REQ-019 Gx SHALL equal (ur+2mr+dr)-(ul+2ml+dl), and Gy SHALL equal (dl+2dc+dr)-(ul+2uc+ur), both as 11-bit signed values with no overflow.
REQ-020 The pipeline SHALL be three stages: S1 computes the partial sums and Gx/Gy; S2 computes |Gx|+|Gy| as an 11-bit unsigned value; S3 saturates, applies the threshold, and registers the outputs.
REQ-021 Latency SHALL be exactly 3 cycles from in_valid to out_valid; throughput SHALL be one pixel per cycle; there SHALL be no backpressure.
REQ-022 Valid SHALL propagate with each pixel, so input bubbles appear as out_valid=0 bubbles.
REQ-023 mag SHALL equal min(|Gx|+|Gy|, 255).
REQ-024 edge SHALL be 1 iff mag >= the thresh sampled with that pixel; thresh=0 SHALL mark every non-border pixel as an edge.
REQ-025 A border pixel (in_x=0, in_x=HEIGHT-1, in_y=0 or in_y=WIDTH-1) SHALL output mag=0 and edge=0, with coordinates passed through.
REQ-026 out_x, out_y, mag and edge SHALL hold their last values when out_valid=0.
REQ-027 frame_done SHALL pulse for one cycle, coincident with out_valid, when out_x=HEIGHT-1 and out_y=WIDTH-1.
REQ-028 Pixels with in_x>=HEIGHT or in_y>=WIDTH SHALL set coord_err=1 (sticky until reset), and SHALL be dropped with no output.

Reset
REQ-029 On rst, all stage valids SHALL clear, and in-flight pixels SHALL be discarded without output.
REQ-030 Reset values SHALL be: out_valid=0, out_x=0, out_y=0, mag=0, edge=0, frame_done=0, edge_count=0, coord_err=0.
REQ-031 rst asserted on the same cycle as in_valid SHALL drop that pixel.

Configuration
REQ-032 With macro SOBEL_EDGE_COUNT_EN defined, an internal accumulator SHALL increment on each out_valid&&edge.
REQ-033 On frame_done, edge_count SHALL load the accumulator value plus that cycle's edge, and the accumulator SHALL clear to 0 in the same cycle.
REQ-034 The accumulator SHALL saturate at 2^CNT_W-1.
REQ-035 Without SOBEL_EDGE_COUNT_EN, edge_count SHALL be tied to 0 and no accumulator logic SHALL exist.

Structure
REQ-036 Shared package sobel_pkg SHALL hold the MAG_MAX=255 constant, the gradient width GRAD_W=11, and the pixel typedef (8-bit) and gradient typedef (11-bit signed).
REQ-037 One sub-module, sobel_grad_core (combinational Gx/Gy/abs from a window), SHALL be instantiated in S1/S2; control, border, threshold and counter logic SHALL stay in the top level.

Verification
REQ-038 Uniform window, all taps =100, at (10,10), thresh=50 -> 3 cycles later out_valid=1, mag=0, edge=0.
REQ-039 Vertical step (left column 0, right column 255, centre column any value) at (5,5), thresh=100 -> Gx=1020, mag=255 (saturated), edge=1.
REQ-040 Same step at (0,5) and at (5,WIDTH-1) -> mag=0, edge=0, with coordinates echoed.
REQ-041 Back-to-back input stream with in_valid pattern 1,0,1,1 -> out_valid pattern 1,0,1,1 delayed by exactly 3 cycles.
REQ-042 Full frame where 7 interior pixels are edges, with SOBEL_EDGE_COUNT_EN defined -> frame_done pulses once at (HEIGHT-1,WIDTH-1), edge_count=7, and the next frame restarts at 0.
REQ-043 rst asserted while 2 pixels are in flight -> no out_valid in the following 3 cycles; in_x=HEIGHT -> coord_err=1 and no output.
